// File: rtl/button_pkg.sv
// Shared types and defaults for the button input conditioning stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package button_pkg;

    // Per-channel debounce FSM: two stable levels plus a qualifying state
    // for each direction of change.
    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } db_state_t;

    localparam int BTN_COUNT            = 5;
    // 20 ms at 50 MHz
    localparam int BTN_DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, edge pulses, optional toggle.
// Latency: level/pulse update DEBOUNCE_CYCLES+1 edges after the first edge that samples a stable raw value.
// Backpressure: none; free-running, outputs are registered levels and one-cycle pulses.
//
// Ports: clk, rst_n (async active-low); raw (async bouncing input);
//        level (debounced), rise/fall (one-cycle pulses), toggle (BUTTON_TOGGLE_EN only, else 0).
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic toggle
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle debounce the count starts at its terminal value so the
    // WAIT state exits on the next edge and the counter never exceeds CNT_LAST.
    localparam logic [CNT_W-1:0] CNT_FIRST = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_W'(1);

    logic             sync1;
    logic             sync2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                S_LO: begin
                    if (sync2) begin
                        state <= S_WAIT_HI;
                        cnt   <= CNT_FIRST;
                    end
                end
                S_WAIT_HI: begin
                    if (!sync2) begin
                        state <= S_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HI;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HI: begin
                    if (!sync2) begin
                        state <= S_WAIT_LO;
                        cnt   <= CNT_FIRST;
                    end
                end
                S_WAIT_LO: begin
                    if (sync2) begin
                        state <= S_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_TOGGLE_EN
    // Flips on the same edge that registers rise, so toggle and rise move together.
    logic accept_hi;
    assign accept_hi = (state == S_WAIT_HI) && sync2 && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle <= 1'b0;
        end else if (accept_hi) begin
            toggle <= ~toggle;
        end
    end
`else
    assign toggle = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Debounces N_BTN raw asynchronous buttons into clean levels, rise/fall pulses and optional toggles.
// Latency: outputs update at edge k+1+DEBOUNCE_CYCLES for a raw change stable from edge k.
// Backpressure: none; every channel is free-running and independent.
//
// Ports: clk, rst_n (async active-low); btn_raw[N_BTN] (async, bouncing, 1 = pressed);
//        btn_level (debounced, drives downstream sw bus), btn_rise/btn_fall (one-cycle pulses),
//        btn_toggle (toggle per rise when BUTTON_TOGGLE_EN is defined, otherwise tied to 0).
module button_debounce
    import button_pkg::*;
#(
    parameter int N_BTN           = BTN_COUNT,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_toggle
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (btn_raw[i]),
            .level  (btn_level[i]),
            .rise   (btn_rise[i]),
            .fall   (btn_fall[i]),
            .toggle (btn_toggle[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce: stable-run reference model feeds a scoreboard queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_debounce;
    localparam int N  = 5;
    localparam int DC = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;
    logic [N-1:0] btn_toggle;

    button_debounce #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .btn_toggle (btn_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] tog;
    } obs_t;

    obs_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    string phase    = "reset";

    // Reference model: a channel accepts a new level once its synchronized
    // input has disagreed with the current level for DC consecutive edges.
    logic m_s1[N], m_s2[N], m_lvl[N], m_tog[N];
    int   m_run[N];

    always @(posedge clk) begin
        obs_t e;
        e = '0;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0;
                m_tog[i] = 1'b0; m_run[i] = 0;
            end else begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) begin
                            e.rise[i] = 1'b1;
`ifdef BUTTON_TOGGLE_EN
                            m_tog[i] = ~m_tog[i];
`endif
                        end else begin
                            e.fall[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = btn_raw[i];
            end
            e.lvl[i] = m_lvl[i];
            e.tog[i] = m_tog[i];
        end
        exp_q.push_back(e);
    end

    // Monitor: pops one expectation per clock and compares away from the edge.
    always @(posedge clk) begin
        obs_t a, e;
        #1;
        a = {btn_level, btn_rise, btn_fall, btn_toggle};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s cycle %0d: scoreboard empty, got lvl=%b rise=%b fall=%b tog=%b",
                     phase, cyc, a.lvl, a.rise, a.fall, a.tog);
        end else begin
            e = exp_q.pop_front();
            if (a === e) n_pass++;
            else $display("FAIL %s cycle %0d: got lvl=%b rise=%b fall=%b tog=%b, expected lvl=%b rise=%b fall=%b tog=%b",
                          phase, cyc, a.lvl, a.rise, a.fall, a.tog, e.lvl, e.rise, e.fall, e.tog);
        end
    end

    task automatic drive(input logic [N-1:0] v, input int n);
        btn_raw = v;
        repeat (n) @(negedge clk);
    endtask

    int hold[N];

    initial begin
        rst_n   = 1'b0;
        btn_raw = '0;
        // Reset with all buttons pressed: outputs stay 0.
        drive(5'b11111, 6);
        btn_raw = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'b00000, 3);

        phase = "clean_press";
        drive(5'b00001, 10);

        phase = "bounce";
        for (int r = 0; r < 5; r++) begin
            drive(5'b00101, 3);
            drive(5'b00001, 1);
        end
        drive(5'b00001, 8);

        phase = "release";
        drive(5'b00000, 10);

        phase = "simultaneous";
        drive(5'b10101, 10);
        drive(5'b11111, 10);
        drive(5'b00000, 10);

        phase = "reset_mid";
        drive(5'b10000, 3);
        rst_n = 1'b0;
        drive(5'b10000, 2);
        rst_n = 1'b1;
        drive(5'b10000, 10);
        phase = "toggle";
        drive(5'b00000, 10);
        drive(5'b10000, 10);
        drive(5'b00000, 10);
        drive(5'b10000, 10);
        drive(5'b00000, 10);

        phase = "random";
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 9);
                end
                hold[i]--;
            end
            rst_n = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        drive(5'b00000, 12);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
